// File: rtl/fact_mmio_if.sv
// Bus and accelerator handshake bundle for fact_mmio.
// slave is the view the MMIO block takes. master is the core/accelerator side.
interface fact_mmio_if #(
    parameter int RES_W = 32
) ();
    logic             we;
    logic [1:0]       a;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic [3:0]       fact_n;
    logic             fact_go;
    logic             fact_done;
    logic             fact_err;
    logic [RES_W-1:0] fact_nf;

    modport slave  (input  we, a, wd, fact_done, fact_err, fact_nf,
                    output rd, fact_n, fact_go);
    modport master (output we, a, wd, fact_done, fact_err, fact_nf,
                    input  rd, fact_n, fact_go);
endinterface

// File: rtl/fact_mmio.sv
// fact_mmio: four-word register window in front of the factorial accelerator.
// It latches the operand, pulses go for one cycle and waits for done/err or a
// timeout. It then holds the result and sticky status until the next start.
module fact_mmio #(
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    fact_mmio_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GO   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Last WAIT count before giving up (counter starts at 0 in the first WAIT cycle)
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_n;
    logic [3:0]       r_shadow;
    logic             r_done;
    logic             r_err;
    logic             r_tmo;
    logic [RES_W-1:0] r_result;
    logic [15:0]      r_cnt;

    logic             w_busy;
    logic             w_start;
    logic             w_wr_n;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_busy   = (r_state != S_IDLE);
    assign w_wr_n   = bus.we && (bus.a == 2'd0);
    // Start requests while busy are dropped; only IDLE consumes them
    assign w_start  = bus.we && (bus.a == 2'd1) && bus.wd[0];
    assign w_unused = ^bus.wd[31:4];

    assign bus.fact_go = (r_state == S_GO);
    assign bus.fact_n  = r_shadow;
    assign bus.rd      = w_rd;

    // Operand register: writable at any time, does not disturb a running op
    always_ff @(posedge clk) begin
        if (rst)         r_n <= 4'd0;
        else if (w_wr_n) r_n <= bus.wd[3:0];
    end

    // Control FSM with sticky status capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shadow <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_result <= '0;
            r_cnt    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shadow <= r_n;
                        r_done   <= 1'b0;
                        r_err    <= 1'b0;
                        r_tmo    <= 1'b0;
                        r_result <= '0;
                        r_cnt    <= 16'd0;
                        r_state  <= S_GO;
                    end
                end
                S_GO: r_state <= S_WAIT;
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    // err outranks done when both arrive together
                    if (bus.fact_err) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (bus.fact_done) begin
                        r_result <= bus.fact_nf;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == TMO_LAST) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read mux: purely combinational, so same-cycle writes are not visible yet
    always_comb begin
        w_rd = 32'd0;
        case (bus.a)
            2'd0:    w_rd = {28'd0, r_n};
            2'd2:    w_rd = {28'd0, r_tmo, w_busy, r_err, r_done};
            2'd3:    w_rd = 32'(r_result);
            default: w_rd = 32'd0;
        endcase
    end
endmodule
